// File: rtl/mult_seq_ctrl.sv
// Iterative shift-add multiplier: valid/ready operand in, one multiplier bit per cycle, valid/ready product out.
// Ports: clk, rst (sync, high), in_valid/in_ready/a/b in; out_valid/out_ready/product out; busy in CALC/DONE.
module mult_seq_ctrl #(
  parameter int a_width    = 8,
  parameter int b_width    = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [a_width-1:0]         a,
  input  logic [b_width-1:0]         b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [a_width+b_width-1:0] product,
  output logic                       busy
);

  localparam int product_width = a_width + b_width;
  localparam int CW = $clog2(b_width + 1);
  localparam logic [CW-1:0] LAST = CW'(b_width - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [product_width-1:0] r_mcand;
  logic [product_width-1:0] r_acc;
  logic [product_width-1:0] r_product;
  logic [b_width-1:0]       r_mult;
  logic [CW-1:0]            r_cnt;

  logic [b_width-1:0]       w_mult_shr;
  logic [product_width-1:0] w_acc_nxt;
  logic                     w_last;
  logic                     w_accept;
  logic                     w_out_fire;
  logic                     w_in_calc;

  assign w_mult_shr = r_mult >> 1;
  assign w_acc_nxt  = r_mult[0] ? (r_acc + r_mcand) : r_acc;
  assign w_in_calc  = (r_state == S_CALC);

  // Early exit: nothing left to add once the remaining multiplier is zero.
  assign w_last = (r_cnt == LAST) ||
                  (EARLY_EXIT && (w_mult_shr == '0));

  assign w_accept   = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand   <= '0;
      r_mult    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_mcand <= product_width'(a);
      r_mult  <= b;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_in_calc) begin
      r_acc   <= w_acc_nxt;
      r_mcand <= r_mcand << 1;
      r_mult  <= w_mult_shr;
      r_cnt   <= r_cnt + CW'(1);
      // Product is captured once and then held, even across later ops,
      // until the next result replaces it.
      if (w_last) begin
        r_product <= w_acc_nxt;
      end
    end
  end

  assign product = r_product;

  logic w_unused;
  assign w_unused = w_out_fire;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl over four width/early-exit configurations.
// Driver pushes expected product and CALC length at accept; monitor pops on first out_valid.
module tb_mult_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    longint p;
    int     k;
    int     t;
  } exp_t;

  task automatic check(input string nm, input longint act,
                       input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int AW = (g < 2) ? 8 : 12;
    localparam int BW = (g < 2) ? 8 : 5;
    localparam bit EE = ((g % 2) == 0);
    localparam int PW = AW + BW;

    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] a = '0;
    logic [BW-1:0] b = '0;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] product;
    logic          busy;

    int     or_mode = 1;
    bit     fin = 1'b0;
    int     cyc = 0;
    exp_t   q[$];
    int     n_in = 0;
    int     n_out = 0;
    bit     prev_ov = 1'b0;
    bit     exp_idle = 1'b0;
    longint held = 0;

    mult_seq_ctrl #(
      .a_width(AW),
      .b_width(BW),
      .EARLY_EXIT(EE)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .a(a),
      .b(b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .product(product),
      .busy(busy)
    );

    // CALC length: position of highest set multiplier bit plus one.
    function automatic int model_k(input longint bv);
      int k = 1;
      if (!EE) return BW;
      for (int i = 0; i < BW; i++) if (bv[i]) k = i + 1;
      return k;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
      #2;
      if (or_mode == 2) out_ready = 1'($urandom_range(0, 1));
      else out_ready = (or_mode == 1);
    end

    always @(negedge clk) begin
      if (rst) begin
        n_in -= q.size();
        q.delete();
        exp_idle = 1'b1;
        prev_ov  = 1'b0;
      end else begin
        if (exp_idle) begin
          check("idle_out_valid", out_valid, 0);
          check("idle_in_ready", in_ready, 1);
          exp_idle = 1'b0;
        end
        check("in_ready_vs_busy", in_ready, !busy);
        if (out_valid) begin
          if (!prev_ov) begin
            if (q.size() == 0) begin
              check("unexpected_output", 1, 0);
            end else begin
              exp_t e;
              e = q.pop_front();
              check("product", product, e.p);
              check("latency", cyc - e.t, e.k + 1);
              n_out++;
            end
            held = longint'(product);
          end else begin
            check("held_product", product, held);
          end
        end
        if (out_valid && out_ready) exp_idle = 1'b1;
        if (in_valid && in_ready) begin
          q.push_back('{p: longint'(a) * longint'(b),
                        k: model_k(longint'(b)), t: cyc});
          n_in++;
        end
        prev_ov = out_valid;
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic send(input longint va, input longint vb);
      int n = 0;
      a = AW'(va);
      b = BW'(vb);
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 300) begin
        @(negedge clk);
        n++;
      end
      check("accept_timeout", in_ready, 1);
      tick();
      in_valid = 1'b0;
    endtask

    task automatic drain();
      int n = 0;
      while ((q.size() != 0 || busy) && n < 500) begin
        tick();
        n++;
      end
      check("drain_timeout", busy, 0);
    endtask

    initial begin
      int n;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_product", product, 0);
      tick();

      send(13, 11);   drain();
      send(255, 255); drain();
      send(200, 0);   drain();
      send(0, 128);   drain();
      send(-1, -1);   drain();

      or_mode = 0;
      send(7, 6);
      n = 0;
      while (!out_valid && n < 100) begin
        tick();
        n++;
      end
      check("bp_wait", out_valid, 1);
      for (int i = 0; i < 5; i++) begin
        in_valid = (i % 2 == 0);
        a = AW'(9);
        b = BW'(9);
        tick();
        check("bp_out_valid", out_valid, 1);
        check("bp_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      or_mode = 1;
      drain();

      send(3, 5);
      a = '1;
      b = '1;
      drain();

      send(100, 200);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_out_valid", out_valid, 0);
      tick();
      send(12, 12);
      drain();

      or_mode = 2;
      for (int i = 0; i < 500; i++) begin
        longint va;
        longint vb;
        va = ($urandom_range(0, 7) == 0) ? 0 : longint'($urandom);
        vb = ($urandom_range(0, 7) == 0) ? 0 : longint'($urandom);
        if ($urandom_range(0, 9) == 0) vb = -1;
        repeat ($urandom_range(0, 3)) tick();
        send(va, vb);
      end
      or_mode = 1;
      tick();
      drain();
      check("ops_in_vs_out", n_out, n_in);
      fin = 1'b1;
    end
  end

  initial begin
    int n = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin &&
             g_cfg[2].fin && g_cfg[3].fin) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    check("global_timeout", n < 60000, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
Iterative shift-add multiplier controller. It accepts one operand pair over a valid/ready handshake, sequences a one-bit-per-cycle multiply datapath through an FSM, and presents the product over a second valid/ready handshake. It is the area-lean, sequenced alternative to the combinational multiplier, for use wherever a product is needed at low rate.

Parameters:
a_width, 8, multiplicand width (bits), >=1
b_width, 8, multiplier width (bits), >=1; bounds CALC iterations
EARLY_EXIT, 1, 1 = leave CALC once no set multiplier bits remain; 0 = always b_width CALC cycles
(localparam product_width = a_width + b_width)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept operands (high only in IDLE)
a  input  a_width  multiplicand, unsigned
b  input  b_width  multiplier, unsigned
out_valid  output  1  product valid (high only in DONE)
out_ready  input  1  consumer accepts product
product  output  product_width  unsigned a*b, exact, no truncation
busy  output  1  high in CALC or DONE

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, acc=0, product=0, out_valid=0, busy=0, iteration count=0. in_ready=1 from the first cycle after reset.
- rst overrides every other input in any state. A reset during CALC or DONE discards the operation with no output.
- Internal registers: mcand (product_width, a zero-extended), mult (b_width), acc (product_width), cnt (clog2(b_width+1) bits).
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at edge T0: mcand<=a, mult<=b, acc<=0, cnt<=0, go to CALC.
  - a and b are sampled only at this edge; later changes are ignored.
- CALC, per cycle:
  - if mult[0], acc<=acc+mcand.
  - mcand<=mcand<<1, mult<=mult>>1, cnt<=cnt+1.
  - Addition is product_width wide and cannot overflow.
- CALC exit, evaluated in the same cycle, go to DONE when:
  - EARLY_EXIT=0: cnt==b_width-1.
  - EARLY_EXIT=1: (mult>>1)==0 OR cnt==b_width-1.
- CALC cycle count k:
  - EARLY_EXIT=0: k=b_width.
  - EARLY_EXIT=1: k = index of MSB set in b, plus 1; k=1 when b==0.
  - k does not depend on a.
- Latency: CALC occupies cycles T0+1..T0+k. out_valid and product are valid from cycle T0+k+1.
- DONE:
  - out_valid=1, product=acc.
  - Both are held stable until out_valid && out_ready at an edge; the FSM then goes to IDLE.
  - out_valid=0 and in_ready=1 in the next cycle. There is no same-cycle accept of a new operand in DONE.
  - product retains its last value after the handshake; only out_valid qualifies it.
- in_valid while busy: ignored, not queued; in_ready=0.
- out_ready while not in DONE: ignored.
- Throughput: one operation per k+2 cycles minimum (accept, k CALC, 1 DONE with out_ready already high).
- Boundaries:
  - a=0 or b=0 gives product 0.
  - All-ones operands give (2^a_width-1)*(2^b_width-1) with no wrap.
  - b_width=1 gives exactly 1 CALC cycle.

Test Plan:
- Defaults, EARLY_EXIT=1, a=13, b=11, out_ready=1 -> CALC 4 cycles, out_valid at T0+5, product=143, in_ready back at T0+6. Same with EARLY_EXIT=0 -> 8 CALC cycles, out_valid at T0+9, product=143.
- a=255, b=255 -> product=65025 after 8 CALC cycles. a=200, b=0 -> product=0 after 1 CALC cycle. a=0, b=128 -> product=0 after 8 cycles.
- Backpressure: a=7, b=6, out_ready=0 for 5 cycles after out_valid -> product=42 and out_valid held, in_ready=0; in_valid pulses with a=9, b=9 meanwhile are ignored. Raise out_ready -> one handshake, then IDLE.
- Operand change after accept: a=3, b=5 accepted, then a and b driven to 255 during CALC -> product=15.
- rst pulsed for 1 cycle at CALC cycle 2 of a=100, b=200 -> next cycle out_valid=0, busy=0, in_ready=1, no product handshake. Follow-up a=12, b=12 -> product=144.
- Random regression: 2000 ops with random in_valid/out_ready gaps, configs (8,8) and (12,5), both EARLY_EXIT values -> every product equals a*b, k matches the formula, and the op count in equals the op count out.
